rptr_empty_ctl: RTL and testbench
=================================

# rptr_empty_ctl

Read-side controller for the asynchronous FIFO, the reader counterpart of the quadrant-direction pointer comparator. It owns the read pointer, which it drives to the comparator as Gray code, and the binary memory address. It turns the comparator's asynchronous active-low almost-empty output into a clean `rempty` in the read clock domain, and registers read data out of the dual-port memory. It sits between the FIFO memory/comparator and the read-domain consumer.

## Interface
Parameters:
- `ASIZE`, 4: pointer/address width; FIFO depth is 2^ASIZE.
- `DSIZE`, 8: data width.

Ports:
- `rclk`  in  1  read clock; all state is on its rising edge.
- `rrst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `rinc`  in  1  read request / pop.
- `aempty_n`  in  1  from comparator; low = pointers equal and heading empty; asynchronous to `rclk`.
- `rdata_mem`  in  DSIZE  memory read data; combinational read at `raddr`.
- `rptr`  out  ASIZE  registered Gray read pointer, to comparator.
- `raddr`  out  ASIZE  registered binary read address, to memory.
- `rempty`  out  1  FIFO empty, read-domain.
- `rdata`  out  DSIZE  registered read data.
- `rvalid`  out  1  `rdata` holds a valid word.

## Operation
- Reset values on `rrst_n` low at a clock edge: `raddr`=0, `rptr`=0, internal binary count=0, `rempty`=1, empty-sync stage=1, `rvalid`=0, `rdata`=0.
- Pointer: binary count `rbin` (ASIZE bits). A fetch increments it modulo 2^ASIZE, so 2^ASIZE−1 wraps to 0. `raddr`<=next `rbin`; `rptr`<=next `rbin` ^ (next `rbin` >> 1). Both register together, so only one `rptr` bit changes per fetch.
- Fetch condition (non-FWFT): `rinc && !rempty`. `rinc` while `rempty`=1 is ignored: pointer, `rdata` and `rvalid` are unchanged.
- Empty flag: two flops, `rempty2` then `rempty`.
  - While `aempty_n` is low, both are preset asynchronously. This is the only asynchronous path; it belongs to the comparator protocol and is not a reset.
  - Otherwise they shift: `rempty2`<=0, `rempty`<=`rempty2`.
  - `rrst_n` low sets both, synchronously.
  - Simultaneous `aempty_n` low and reset: both flops are 1.
- Data (non-FWFT): on a fetch, `rdata`<=`rdata_mem` and `rvalid`<=1. On any other cycle `rvalid`<=0 and `rdata` holds.
- Reset mid-operation aborts any in-flight word: `rvalid`=0 on the next cycle and the pointer returns to 0. The write side must be reset too.

## Timing
- Read latency (non-FWFT): `rdata`/`rvalid` appear 1 cycle after the accepting `rclk` edge.
- `rempty` assertion is immediate, a combinational delay after `aempty_n` falls. `aempty_n` falls because `rptr` advanced, so the flag is set before the next edge, and a read past empty is impossible.
- `rempty` deassertion occurs on the 2nd `rclk` rising edge after `aempty_n` rises.
- Back-to-back fetches are allowed every cycle while `rempty`=0.

## Configuration
- `FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - Fetch condition becomes `!rempty && (!rvalid || rinc)`.
  - On a fetch, `rdata`<=`rdata_mem` and `rvalid`<=1.
  - `rinc && rvalid` without a fetch sets `rvalid`<=0.
  - `rinc` with `rvalid`=0 is ignored.
  - The head word appears 1 cycle after `rempty` falls without a request; `rvalid` is the consumer's not-empty indication.
- `FIFO_FWFT_EN` undefined: standard mode as described in Operation; the FWFT logic is absent.

## Test plan
- Reset: hold `rrst_n`=0 for 2 edges with `aempty_n`=1 -> `rptr`=0, `raddr`=0, `rempty`=1, `rvalid`=0; after release, `rempty`=0 on the 2nd edge.
- Empty sync: `aempty_n` 0->1 mid-cycle -> `rempty` falls exactly 2 edges later; `aempty_n` 1->0 -> `rempty`=1 with no clock edge.
- Read sequence: preload memory so each word = its address; with `aempty_n`=1, hold `rinc`=1 for 3 cycles -> `rdata` 0,1,2 each 1 cycle after its accept; `rptr` 0->1->3->2.
- Wrap: with ASIZE=4, 17 fetches -> `raddr` 15->0; `rptr` visits 16 distinct codes and changes exactly 1 bit per step.
- Read while empty: `aempty_n`=0, `rinc`=1 for 4 cycles -> `rptr`, `rdata` unchanged, `rvalid`=0.
- FWFT (`FIFO_FWFT_EN`): `aempty_n` rises with memory word 0xA5 at the head -> `rdata`=0xA5, `rvalid`=1 with `rinc`=0. Then a reset mid-stream -> `rvalid`=0 and `rptr`=0 on the next edge.

Source files
------------

// File: rtl/rptr_empty_ctl_if.sv
// Read-side bundle between the read pointer controller and the FIFO memory, comparator and consumer.
// master = controller side (drives pointer, flag and data); slave = surrounding logic / consumer.
interface rptr_empty_ctl_if #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
);
    logic             rinc;
    logic             aempty_n;
    logic [DSIZE-1:0] rdata_mem;
    logic [ASIZE-1:0] rptr;
    logic [ASIZE-1:0] raddr;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;

    modport master (
        input  rinc, aempty_n, rdata_mem,
        output rptr, raddr, rempty, rdata, rvalid
    );

    modport slave (
        output rinc, aempty_n, rdata_mem,
        input  rptr, raddr, rempty, rdata, rvalid
    );
endinterface

// File: rtl/rptr_empty_ctl.sv
// Async FIFO read controller: Gray read pointer, binary address, synchronised empty flag, registered data.
// Latency: rdata/rvalid 1 rclk after an accepted fetch; rempty sets asynchronously, clears 2 edges after aempty_n rises.
// Backpressure: fetches are blocked while rempty; FIFO_FWFT_EN selects first-word-fall-through prefetch.
module rptr_empty_ctl #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    rptr_empty_ctl_if.master     rif
);

    logic [ASIZE-1:0] rbin_q,  rbin_d;
    logic [ASIZE-1:0] rptr_q,  rptr_d;
    logic [ASIZE-1:0] raddr_q, raddr_d;
    logic             rempty2_q, rempty2_d;
    logic             rempty_q,  rempty_d;
    logic             rvalid_q,  rvalid_d;
    logic [DSIZE-1:0] rdata_q,   rdata_d;
    logic             fetch;
    logic             aempty_n;

    assign aempty_n = rif.aempty_n;

    always_comb begin
`ifdef FIFO_FWFT_EN
        fetch = !rempty_q && (!rvalid_q || rif.rinc);
`else
        fetch = rif.rinc && !rempty_q;
`endif
        rbin_d  = rbin_q + {{(ASIZE-1){1'b0}}, fetch};
        raddr_d = rbin_d;
        rptr_d  = rbin_d ^ (rbin_d >> 1);
        rdata_d = fetch ? rif.rdata_mem : rdata_q;
`ifdef FIFO_FWFT_EN
        // In FWFT the word stays valid until the consumer pops it.
        rvalid_d = rvalid_q;
        if (fetch) begin
            rvalid_d = 1'b1;
        end else if (rif.rinc && rvalid_q) begin
            rvalid_d = 1'b0;
        end
`else
        rvalid_d = fetch;
`endif
        rempty2_d = 1'b0;
        rempty_d  = rempty2_q;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // The comparator's async preset is what makes rempty rise before the next edge.
    always_ff @(posedge rclk or negedge aempty_n) begin
        if (!aempty_n) begin
            rempty2_q <= 1'b1;
            rempty_q  <= 1'b1;
        end else if (!rrst_n) begin
            rempty2_q <= 1'b1;
            rempty_q  <= 1'b1;
        end else begin
            rempty2_q <= rempty2_d;
            rempty_q  <= rempty_d;
        end
    end

    assign rif.rptr   = rptr_q;
    assign rif.raddr  = raddr_q;
    assign rif.rempty = rempty_q;
    assign rif.rdata  = rdata_q;
    assign rif.rvalid = rvalid_q;

endmodule

// File: tb/tb_rptr_empty_ctl.sv
// Randomised and directed bench for rptr_empty_ctl against a fetch-count reference model.
module tb_rptr_empty_ctl;
    localparam int ASIZE = 4;
    localparam int DSIZE = 8;
    localparam int DEPTH = 16;

    logic rclk = 1'b0;
    logic rrst_n;
    always #5 rclk = ~rclk;

    rptr_empty_ctl_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) rif ();

    logic [DSIZE-1:0] mem [DEPTH];
    assign rif.rdata_mem = mem[rif.raddr];

    rptr_empty_ctl #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rif    (rif)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: total words fetched, output word, edges seen with aempty_n high.
    int         m_cnt;
    bit         m_rvalid;
    logic [7:0] m_rdata;
    int         m_sync;

    logic [17:0] dut_vec;
    assign dut_vec = {rif.rptr, rif.raddr, rif.rempty, rif.rvalid, rif.rdata};

    function automatic bit exp_empty();
        return (rif.aempty_n === 1'b0) || (m_sync < 2);
    endfunction

    function automatic logic [3:0] gray_of(int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [3:0] b;
        b = m_cnt[3:0];
        return {gray_of(m_cnt), b, exp_empty(), m_rvalid, m_rdata};
    endfunction

    // Advance model across one rising edge using the inputs present now, then settle.
    task automatic tick();
        bit emp;
        bit fetch;
        emp = exp_empty();
`ifdef FIFO_FWFT_EN
        fetch = !emp && (!m_rvalid || rif.rinc);
`else
        fetch = rif.rinc && !emp;
`endif
        if (!rrst_n) begin
            m_cnt = 0; m_rvalid = 0; m_rdata = '0; m_sync = 0;
        end else begin
            if (fetch) begin
                m_rdata  = mem[m_cnt % DEPTH];
                m_rvalid = 1;
                m_cnt    = m_cnt + 1;
            end else begin
`ifdef FIFO_FWFT_EN
                if (rif.rinc && m_rvalid) m_rvalid = 0;
`else
                m_rvalid = 0;
`endif
            end
            m_sync = (rif.aempty_n === 1'b1) ? ((m_sync < 2) ? m_sync + 1 : 2) : 0;
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0; rif.rinc = 1'b0; rif.aempty_n = 1'b1;
        tick(); tick();
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] want;
        rrst_n = 1'b0; rif.rinc = 1'b0; rif.aempty_n = 1'b1;
        tick(); tick();
        want = {4'd0, 4'd0, 1'b1, 1'b0, 8'd0};
        vectors++;
        if (dut_vec !== want) begin
            errors++; $display("FAIL reset_state: got %h want %h", dut_vec, want);
        end
        rrst_n = 1'b1;
        tick();
        vectors++;
        if (rif.rempty !== 1'b1) begin
            errors++; $display("FAIL reset_empty_edge1: got %b want 1", rif.rempty);
        end
        tick();
        vectors++;
        if (rif.rempty !== 1'b0) begin
            errors++; $display("FAIL reset_empty_edge2: got %b want 0", rif.rempty);
        end
    endtask

    task automatic test_empty_sync();
        rif.rinc = 1'b0;
        @(negedge rclk);
        rif.aempty_n = 1'b0;
        #1;
        vectors++;
        if (rif.rempty !== 1'b1) begin
            errors++; $display("FAIL empty_async_set: got %b want 1", rif.rempty);
        end
        tick(); tick();
        @(negedge rclk);
        rif.aempty_n = 1'b1;
        tick();
        vectors++;
        if (rif.rempty !== 1'b1) begin
            errors++; $display("FAIL empty_clear_edge1: got %b want 1", rif.rempty);
        end
        tick();
        vectors++;
        if (rif.rempty !== 1'b0) begin
            errors++; $display("FAIL empty_clear_edge2: got %b want 0", rif.rempty);
        end
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL empty_sync_state: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_read_seq();
        logic [3:0] rp_tab [3];
        rp_tab[0] = 4'd1; rp_tab[1] = 4'd3; rp_tab[2] = 4'd2;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        do_reset();
        tick(); tick();
        rif.rinc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL read_seq_model[%0d]: got %h want %h", k, dut_vec, exp_vec());
            end
`ifndef FIFO_FWFT_EN
            vectors++;
            if ({rif.rvalid, rif.rdata, rif.rptr} !== {1'b1, 8'(k), rp_tab[k]}) begin
                errors++; $display("FAIL read_seq[%0d]: got v=%b d=%h p=%h want v=1 d=%h p=%h",
                                   k, rif.rvalid, rif.rdata, rif.rptr, 8'(k), rp_tab[k]);
            end
`endif
        end
        rif.rinc = 1'b0;
        tick();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL read_seq_idle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        bit [15:0]  seen;
        int         distinct;
        do_reset();
        tick(); tick();
        prev = rif.rptr; seen = '0; seen[prev] = 1'b1;
        rif.rinc = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            vectors++;
            if (rif.raddr !== 4'(k % DEPTH) || $countones(rif.rptr ^ prev) != 1) begin
                errors++; $display("FAIL wrap_step[%0d]: got raddr=%h rptr=%h prev=%h want raddr=%h one-bit step",
                                   k, rif.raddr, rif.rptr, prev, 4'(k % DEPTH));
            end
            prev = rif.rptr;
            if (k < 16) seen[prev] = 1'b1;
        end
        rif.rinc = 1'b0;
        distinct = $countones(seen);
        vectors++;
        if (distinct != 16) begin
            errors++; $display("FAIL wrap_distinct: got %0d codes want 16", distinct);
        end
        tick();
    endtask

    task automatic test_read_empty();
        int         saved_cnt;
        logic [7:0] saved_data;
        saved_cnt = m_cnt; saved_data = m_rdata;
        rif.aempty_n = 1'b0; rif.rinc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({rif.rptr, rif.rvalid, rif.rdata} !== {gray_of(saved_cnt), 1'b0, saved_data}) begin
                errors++; $display("FAIL read_empty[%0d]: got p=%h v=%b d=%h want p=%h v=0 d=%h",
                                   k, rif.rptr, rif.rvalid, rif.rdata, gray_of(saved_cnt), saved_data);
            end
        end
        rif.rinc = 1'b0; rif.aempty_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        rif.aempty_n = 1'b1; rif.rinc = 1'b1;
        tick(); tick(); tick(); tick();
        rrst_n = 1'b0;
        tick();
        vectors++;
        if ({rif.rvalid, rif.rptr, rif.raddr} !== 9'd0) begin
            errors++; $display("FAIL reset_mid: got v=%b p=%h a=%h want all 0", rif.rvalid, rif.rptr, rif.raddr);
        end
        rrst_n = 1'b1; rif.rinc = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rif.rinc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                rif.aempty_n = ~rif.aempty_n;
                #1;
                vectors++;
                if (rif.rempty !== exp_empty()) begin
                    errors++; $display("FAIL random_async[%0d]: got %b want %b", c, rif.rempty, exp_empty());
                end
            end
            rrst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        rrst_n = 1'b1; rif.aempty_n = 1'b1; rif.rinc = 1'b0;
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        mem[0] = 8'hA5;
        do_reset();
        rif.aempty_n = 1'b0; rif.rinc = 1'b0;
        tick();
        @(negedge rclk);
        rif.aempty_n = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if ({rif.rvalid, rif.rdata} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL fwft_head: got v=%b d=%h want v=1 d=a5", rif.rvalid, rif.rdata);
        end
        rrst_n = 1'b0;
        tick();
        vectors++;
        if ({rif.rvalid, rif.rptr} !== 5'd0) begin
            errors++; $display("FAIL fwft_reset: got v=%b p=%h want 0", rif.rvalid, rif.rptr);
        end
        rrst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        rrst_n = 1'b0; rif.rinc = 1'b0; rif.aempty_n = 1'b1;
        m_cnt = 0; m_rvalid = 0; m_rdata = '0; m_sync = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        test_reset();
        test_empty_sync();
        test_read_seq();
        test_wrap();
        test_read_empty();
        test_reset_mid();
        test_random();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
